i2c_reg_slave: RTL
==================

I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h5D, the 7-bit target address (write byte 0xBA, read byte 0xBB).
REQ-002 SHALL have parameter NUM_REGS, default 16, the number of implemented 8-bit registers (2..256).
REQ-003 SHALL have parameter FILT_LEN, default 3, the number of identical consecutive samples required to accept a line level change.
REQ-004 SHALL have the port clk, input, 1 bit: the system clock (27 MHz); the single clock domain.
REQ-005 SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have the port scl_in, input, 1 bit: the raw sampled SCL pad level, asynchronous.
REQ-007 SHALL have the port sda_in, input, 1 bit: the raw sampled SDA pad level, asynchronous.
REQ-008 SHALL have the port sda_oe, output, 1 bit: 1 = drive SDA low, 0 = release; the pad tristate lives outside this block.
REQ-009 SHALL have the port wr_strobe, output, 1 bit: a one-clk pulse for each accepted register write.
REQ-010 SHALL have the port wr_addr, output, 8 bits: the register index of the last write; valid while wr_strobe is high.
REQ-011 SHALL have the port wr_data, output, 8 bits: the data of the last write; valid while wr_strobe is high.
REQ-012 SHALL have the port regs_flat, output, NUM_REGS*8 bits: the register file contents, with reg i at bits [8i+7:8i].
REQ-013 SHALL have the port busy, output, 1 bit: high from a START until the next STOP.

Function
REQ-014 scl_in and sda_in SHALL pass through a 2-FF synchronizer, then a FILT_LEN-sample glitch filter; all logic SHALL use only the filtered levels.
REQ-015 Line events SHALL be defined from the filtered levels: START = SDA falls while SCL is high; STOP = SDA rises while SCL is high; data bits are sampled on the SCL rising edge.
REQ-016 The FSM SHALL have the states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-017 A START detected in any state, including a repeated START mid-byte, SHALL clear the bit counter and go to ADDR.
REQ-018 A STOP detected in any state SHALL go to IDLE and release sda_oe within 1 clk.
REQ-019 ADDR: after 8 bits, a match of [7:1] with DEV_ADDR SHALL lead to ADDR_ACK; a mismatch SHALL lead to IGNORE (no ACK, sda_oe = 0 until the next START or STOP).
REQ-020 sda_oe SHALL change only within 1 clk after a filtered SCL falling edge.
REQ-021 An ACK SHALL assert sda_oe from the falling edge after bit 8 until the following falling edge.
REQ-022 For a write (R/W = 0), the first data byte SHALL load the register pointer and be ACKed (REG, then REG_ACK); each following byte SHALL go through WDATA, then WDATA_ACK.
REQ-023 A write byte SHALL commit at the falling edge that starts its ACK: regs[ptr] is updated, wr_strobe pulses for one clk, and ptr increments mod 256.
REQ-024 A write with ptr >= NUM_REGS SHALL be ACKed and discarded: no strobe, no update, but ptr still increments.
REQ-025 For a read (R/W = 1), RDATA SHALL shift out regs[ptr] MSB first, changing SDA on SCL falling edges; ptr SHALL increment after each byte; ptr >= NUM_REGS SHALL read 0xFF.
REQ-026 RDATA_ACK: an ACK from the master (SDA = 0) SHALL send the next byte; a NACK SHALL go to IGNORE with sda_oe released.
REQ-027 ptr SHALL persist across transactions, so a write of only the pointer followed by a repeated START read works.

Reset
REQ-028 While rst is asserted, the block SHALL hold: state = IDLE, sda_oe = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, busy = 0, ptr = 0, all regs = 0x00, and the synchronizers and filters preset to 1.
REQ-029 A reset asserted mid-transaction SHALL release SDA on the next clk, and the block SHALL ignore the bus until the next START.

Configuration
REQ-030 With macro I2C_SLAVE_READ_EN defined, reads SHALL work as in REQ-025 and REQ-026.
REQ-031 Without I2C_SLAVE_READ_EN, an address byte with R/W = 1 SHALL be NACKed and go to IGNORE, and the RDATA and RDATA_ACK logic SHALL be absent.

Structure
REQ-032 A shared package i2c_pkg SHALL hold the FSM state enum, the default TVP5150 address constant 7'h5D, and the read-pad value 8'hFF.
REQ-033 The synchronizer plus glitch filter SHALL be one sub-module, i2c_line_filter, instantiated twice.

Verification
REQ-034 The bench SHALL cover: master writes 0xBA, 0x03, 0x0D, STOP -> three ACKs; one wr_strobe with wr_addr = 0x03 and wr_data = 0x0D; regs_flat[31:24] = 0x0D.
REQ-035 The bench SHALL cover: address byte 0xB8 -> no ACK on any byte, no wr_strobe, busy high until the STOP.
REQ-036 The bench SHALL cover: write 0xBA, 0x0E, 0xAA, 0xBB, 0xCC -> regs 0x0E = 0xAA and 0x0F = 0xBB; the 0xCC byte is ACKed with no strobe; ptr ends at 0x11.
REQ-037 The bench SHALL cover (with I2C_SLAVE_READ_EN): write 0xBA, 0x02, repeated START, 0xBB, read two bytes (ACK, then NACK) -> the bytes read are regs 0x02 and 0x03; sda_oe = 0 after the NACK.
REQ-038 The bench SHALL cover: a 2-clk low glitch on SCL during a data bit, with FILT_LEN = 3 -> no bit shifted and the transaction completes correctly.
REQ-039 The bench SHALL cover: rst pulsed during ACK low -> sda_oe = 0 on the next clk; all regs = 0x00; the next full write succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : i2c_pkg
//  Description : Shared types and constants for the I2C register slave:
//                FSM state encoding, default TVP5150 target address and the
//                value returned when reading outside the register file.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_REG       = 4'd3,
        S_REG_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_IGNORE    = 4'd9
    } i2c_state_t;

    // 7-bit address of the TVP5150 decoder (0xBA write / 0xBB read)
    localparam logic [6:0] c_TVP5150_ADDR = 7'h5D;

    // Byte returned for reads beyond the implemented registers
    localparam logic [7:0] c_READ_PAD = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_line_filter
//  Description : 2-FF synchronizer followed by a glitch filter for one
//                open-drain bus line. The output only changes after FILT_LEN
//                identical consecutive synchronized samples.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset (presets to 1)
//                line_in  - raw asynchronous pad level
//                line_out - filtered level
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_out
);

    logic [1:0]          r_sync;
    logic [FILT_LEN-1:0] r_hist;
    logic                r_level;

    // Idle bus level is high, so everything presets to 1 to avoid a
    // spurious START/STOP right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_hist  <= '1;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], line_in};
            r_hist <= (r_hist << 1) | FILT_LEN'(r_sync[1]);
            if (&r_hist) begin
                r_level <= 1'b1;
            end else if (~|r_hist) begin
                r_level <= 1'b0;
            end
        end
    end

    assign line_out = r_level;

endmodule
`default_nettype wire

// File: rtl/i2c_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_reg_slave
//  Description : I2C target with an 8-bit register file addressed through an
//                auto-incrementing pointer. Single clock domain; SCL/SDA are
//                synchronized and glitch filtered before use.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                scl_in, sda_in  - raw pad levels (asynchronous)
//                sda_oe          - 1 = pull SDA low
//                wr_strobe       - one-clk pulse per accepted register write
//                wr_addr/wr_data - index/data of the last accepted write
//                regs_flat       - register file, reg i at [8i+7:8i]
//                busy            - high between START and STOP
//  Config      : I2C_SLAVE_READ_EN - define to enable register reads;
//                otherwise a read address byte is NACKed.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = c_TVP5150_ADDR,
    parameter int         NUM_REGS = 16,
    parameter int         FILT_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic                  wr_strobe,
    output logic [7:0]            wr_addr,
    output logic [7:0]            wr_data,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  busy
);

    localparam int         c_IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] c_NUM_REGS = 9'(NUM_REGS);

    // ------------------------------------------------------------------
    // Line conditioning and bus events
    // ------------------------------------------------------------------
    logic w_scl;
    logic w_sda;
    logic r_scl_d;
    logic r_sda_d;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk      (clk),
        .rst      (rst),
        .line_in  (scl_in),
        .line_out (w_scl)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk      (clk),
        .rst      (rst),
        .line_in  (sda_in),
        .line_out (w_sda)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    i2c_state_t         r_state;
    i2c_state_t         w_state_nxt;
    logic [3:0]         r_bit_cnt;
    logic [3:0]         w_cnt_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic [7:0]         r_ptr;
    logic [7:0]         w_ptr_nxt;
    logic               r_sda_oe;
    logic               w_oe_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               w_commit;
    logic [7:0]         r_regs [NUM_REGS];
    logic               r_wr_strobe;
    logic [7:0]         r_wr_addr;
    logic [7:0]         r_wr_data;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_in_range;
    logic               w_addr_ok;

    assign w_idx      = r_ptr[c_IDX_W-1:0];
    assign w_in_range = ({1'b0, r_ptr} < c_NUM_REGS);

`ifdef I2C_SLAVE_READ_EN
    logic       r_mack;
    logic       w_mack_nxt;
    logic [7:0] w_rd_byte;

    assign w_rd_byte = w_in_range ? r_regs[w_idx] : c_READ_PAD;
    assign w_addr_ok = (r_shift[7:1] == DEV_ADDR);
`else
    // Reads are not supported: only a write address byte is acknowledged.
    assign w_addr_ok = (r_shift[7:1] == DEV_ADDR) && !r_shift[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath decode. SDA drive changes only on filtered SCL
    // falling edges (plus release on STOP); r_shift still holds the address
    // byte throughout ADDR_ACK, so its LSB is the R/W bit there.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_ptr_nxt   = r_ptr;
        w_oe_nxt    = r_sda_oe;
        w_busy_nxt  = r_busy;
        w_commit    = 1'b0;
`ifdef I2C_SLAVE_READ_EN
        w_mack_nxt  = r_mack;
`endif
        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
            w_cnt_nxt   = 4'd0;
            w_busy_nxt  = 1'b1;
        end else begin
            case (r_state)
                S_ADDR, S_REG, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], w_sda};
                        w_cnt_nxt   = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        w_cnt_nxt = 4'd0;
                        if (r_state == S_ADDR) begin
                            if (w_addr_ok) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_oe_nxt    = 1'b1;
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end else if (r_state == S_REG) begin
                            w_ptr_nxt   = r_shift;
                            w_state_nxt = S_REG_ACK;
                            w_oe_nxt    = 1'b1;
                        end else begin
                            // Out-of-range writes are ACKed but dropped;
                            // the pointer advances either way.
                            w_commit    = 1'b1;
                            w_ptr_nxt   = r_ptr + 8'd1;
                            w_state_nxt = S_WDATA_ACK;
                            w_oe_nxt    = 1'b1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_oe_nxt    = 1'b0;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_REG;
`ifdef I2C_SLAVE_READ_EN
                        if (r_shift[0]) begin
                            w_state_nxt = S_RDATA;
                            w_shift_nxt = w_rd_byte;
                            w_oe_nxt    = ~w_rd_byte[7];
                        end
`endif
                    end
                end
                S_REG_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_oe_nxt    = 1'b0;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_WDATA;
                    end
                end
`ifdef I2C_SLAVE_READ_EN
                S_RDATA: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_cnt_nxt   = 4'd0;
                            w_oe_nxt    = 1'b0;
                            w_ptr_nxt   = r_ptr + 8'd1;
                            w_state_nxt = S_RDATA_ACK;
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b1};
                            w_oe_nxt    = ~r_shift[6];
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_mack_nxt = ~w_sda;
                    end else if (w_scl_fall) begin
                        if (r_mack) begin
                            w_state_nxt = S_RDATA;
                            w_shift_nxt = w_rd_byte;
                            w_oe_nxt    = ~w_rd_byte[7];
                        end else begin
                            w_state_nxt = S_IGNORE;
                            w_oe_nxt    = 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    // IDLE / IGNORE: wait for START or STOP
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_ptr     <= 8'h00;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
            r_mack    <= 1'b0;
`endif
        end else begin
            r_bit_cnt <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_oe  <= w_oe_nxt;
            r_busy    <= w_busy_nxt;
`ifdef I2C_SLAVE_READ_EN
            r_mack    <= w_mack_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Register file and write strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 8'h00;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_commit && w_in_range) begin
                r_regs[w_idx] <= r_shift;
                r_wr_strobe   <= 1'b1;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= r_shift;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[8*gi +: 8] = r_regs[gi];
        end
    endgenerate

    assign sda_oe    = r_sda_oe;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = r_busy;

endmodule
`default_nettype wire
